// File: rtl/memory_access_unit_if.sv
// memory_access_unit_if: req/ack data-memory bus between the memory stage and data memory.
interface memory_access_unit_if;
    logic        req;
    logic        we;
    logic        ack;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master(output req, we, addr, wdata, input ack, rdata);
    modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/memory_access_unit.sv
// memory_access_unit: memory stage issuing word loads/stores over a req/ack bus,
// stalling the pipeline while an access is outstanding.
module memory_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2:0]                   ctrls_m,
    input  logic [31:0]                  aluout_m,
    input  logic [31:0]                  writedata_m,
    memory_access_unit_if.master         bus,
    output logic [31:0]                  readdata_m,
    output logic                         stall_m,
    output logic                         misaligned_m,
    output logic                         bus_error_m
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_CYCLES - 1);
    state_t     state;
    logic [7:0] cnt;
    logic       access;
    logic       aligned;
    logic       start;
    logic       unused_regwrite;
    assign unused_regwrite = ctrls_m[2];
    assign access       = ctrls_m[0] | ctrls_m[1];
    assign aligned      = aluout_m[1:0] == 2'b00;
    assign start        = state == IDLE && access && aligned;
    assign stall_m      = !reset && (start || state == REQ);
    assign misaligned_m = !reset && state == IDLE && access && !aligned;
    // Store wins when both load and store bits are set, so we is simply the store bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            bus.req     <= 1'b0;
            bus.we      <= 1'b0;
            bus.addr    <= 32'd0;
            bus.wdata   <= 32'd0;
            readdata_m  <= 32'd0;
            bus_error_m <= 1'b0;
        end else begin
            bus_error_m <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= REQ;
                    cnt       <= 8'd0;
                    bus.req   <= 1'b1;
                    bus.we    <= ctrls_m[0];
                    bus.addr  <= {aluout_m[31:2], 2'b00};
                    bus.wdata <= writedata_m;
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (bus.ack) begin
                        state   <= DONE;
                        bus.req <= 1'b0;
                        if (!bus.we) readdata_m <= bus.rdata;
                    end else if (cnt == CNT_MAX) begin
                        state       <= DONE;
                        bus.req     <= 1'b0;
                        bus_error_m <= 1'b1;
                        if (!bus.we) readdata_m <= 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed checks of the memory stage, including a
// short-timeout instance for the bus-error path.
module tb_memory_access_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  ctrls = 3'b000, ctrls_t = 3'b000;
    logic [31:0] addr = 32'd0, addr_t = 32'd0, wdata = 32'd0, wdata_t = 32'd0;
    logic [31:0] rd, rd_t;
    logic        st, st_t, mis, mis_t, be, be_t;
    int          n_cmp = 0;
    int          n_err = 0;
    int          stall_cnt, req_cnt;

    memory_access_unit_if bus();
    memory_access_unit_if bus_t();

    memory_access_unit dut (
        .clk(clk), .reset(reset), .ctrls_m(ctrls), .aluout_m(addr), .writedata_m(wdata),
        .bus(bus), .readdata_m(rd), .stall_m(st), .misaligned_m(mis), .bus_error_m(be)
    );

    memory_access_unit #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .reset(reset), .ctrls_m(ctrls_t), .aluout_m(addr_t), .writedata_m(wdata_t),
        .bus(bus_t), .readdata_m(rd_t), .stall_m(st_t), .misaligned_m(mis_t), .bus_error_m(be_t)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.ack = 1'b0; bus.rdata = 32'd0;
        bus_t.ack = 1'b0; bus_t.rdata = 32'd0;
        tick; tick;
        chk("rst_req", {31'd0, bus.req}, 32'd0);
        chk("rst_stall", {31'd0, st}, 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_berr", {31'd0, be}, 32'd0);
        reset = 1'b0;
        tick;

        // load 0x100, ack in first REQ cycle
        ctrls = 3'b010; addr = 32'h100;
        #1 chk("ld_stall0", {31'd0, st}, 32'd1);
        chk("ld_req0", {31'd0, bus.req}, 32'd0);
        tick;
        chk("ld_req1", {31'd0, bus.req}, 32'd1);
        chk("ld_we", {31'd0, bus.we}, 32'd0);
        chk("ld_addr", bus.addr, 32'h100);
        chk("ld_stall1", {31'd0, st}, 32'd1);
        bus.ack = 1'b1; bus.rdata = 32'hDEADBEEF;
        tick;
        bus.ack = 1'b0; bus.rdata = 32'd0;
        chk("ld_done_stall", {31'd0, st}, 32'd0);
        chk("ld_done_req", {31'd0, bus.req}, 32'd0);
        chk("ld_rd", rd, 32'hDEADBEEF);
        ctrls = 3'b000;
        tick;
        chk("ld_rd_hold", rd, 32'hDEADBEEF);
        chk("ld_idle_req", {31'd0, bus.req}, 32'd0);

        // store 0x204, ack in the 5th REQ cycle
        ctrls = 3'b001; addr = 32'h204; wdata = 32'h12345678;
        stall_cnt = 0; req_cnt = 0;
        #1 stall_cnt += int'(st);
        for (int i = 1; i <= 5; i++) begin
            tick;
            stall_cnt += int'(st);
            req_cnt += int'(bus.req);
            chk("st_we", {31'd0, bus.we}, 32'd1);
            chk("st_addr", bus.addr, 32'h204);
            chk("st_wdata", bus.wdata, 32'h12345678);
            if (i == 5) bus.ack = 1'b1;
        end
        tick;
        bus.ack = 1'b0;
        stall_cnt += int'(st);
        req_cnt += int'(bus.req);
        chk("st_stall_cycles", stall_cnt, 32'd6);
        chk("st_req_cycles", req_cnt, 32'd5);
        chk("st_rd_unchanged", rd, 32'hDEADBEEF);
        ctrls = 3'b000;
        tick;

        // misaligned load at 0x3
        ctrls = 3'b110; addr = 32'h3;
        #1 chk("mis_flag", {31'd0, mis}, 32'd1);
        chk("mis_stall", {31'd0, st}, 32'd0);
        tick;
        chk("mis_req", {31'd0, bus.req}, 32'd0);
        ctrls = 3'b000;
        #1 chk("mis_clear", {31'd0, mis}, 32'd0);
        tick;
        chk("mis_req_after", {31'd0, bus.req}, 32'd0);

        // non-memory instruction
        ctrls = 3'b100; addr = 32'h5;
        #1 chk("nomem_stall", {31'd0, st}, 32'd0);
        chk("nomem_mis", {31'd0, mis}, 32'd0);
        tick;
        chk("nomem_req", {31'd0, bus.req}, 32'd0);
        ctrls = 3'b000;

        // timeout instance: successful load first, then a load with no ack
        ctrls_t = 3'b010; addr_t = 32'h20;
        tick;
        bus_t.ack = 1'b1; bus_t.rdata = 32'hCAFEF00D;
        tick;
        bus_t.ack = 1'b0; ctrls_t = 3'b000;
        chk("to_preload", rd_t, 32'hCAFEF00D);
        tick;
        ctrls_t = 3'b010; addr_t = 32'h80;
        stall_cnt = 0; req_cnt = 0;
        #1;
        for (int i = 0; i < 20; i++) begin
            stall_cnt += int'(st_t);
            req_cnt += int'(bus_t.req);
            if (!st_t) break;
            tick;
        end
        chk("to_req_cycles", req_cnt, 32'd4);
        chk("to_stall_cycles", stall_cnt, 32'd5);
        chk("to_berr", {31'd0, be_t}, 32'd1);
        chk("to_rd_zero", rd_t, 32'd0);
        ctrls_t = 3'b000;
        tick;
        chk("to_berr_clear", {31'd0, be_t}, 32'd0);
        chk("to_req_idle", {31'd0, bus_t.req}, 32'd0);

        // reset in 2nd REQ cycle, then stray ack
        ctrls = 3'b010; addr = 32'h10;
        tick;
        tick;
        chk("rr_req2", {31'd0, bus.req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rr_req", {31'd0, bus.req}, 32'd0);
        chk("rr_stall", {31'd0, st}, 32'd0);
        chk("rr_addr", bus.addr, 32'd0);
        chk("rr_rd", rd, 32'd0);
        ctrls = 3'b000;
        tick;
        reset = 1'b0;
        bus.ack = 1'b1; bus.rdata = 32'h55555555;
        tick;
        bus.ack = 1'b0;
        chk("rr_stray_rd", rd, 32'd0);
        chk("rr_stray_req", {31'd0, bus.req}, 32'd0);
        chk("rr_stray_stall", {31'd0, st}, 32'd0);
        tick;

        // preload then load+store together at 0x40
        ctrls = 3'b010; addr = 32'h8;
        tick;
        bus.ack = 1'b1; bus.rdata = 32'hA5A5A5A5;
        tick;
        bus.ack = 1'b0; ctrls = 3'b000;
        chk("both_preload", rd, 32'hA5A5A5A5);
        tick;
        ctrls = 3'b011; addr = 32'h40; wdata = 32'h00000099;
        #1 chk("both_stall0", {31'd0, st}, 32'd1);
        tick;
        chk("both_we", {31'd0, bus.we}, 32'd1);
        chk("both_addr", bus.addr, 32'h40);
        chk("both_stall1", {31'd0, st}, 32'd1);
        bus.ack = 1'b1; bus.rdata = 32'hFFFFFFFF;
        tick;
        bus.ack = 1'b0;
        chk("both_rd_kept", rd, 32'hA5A5A5A5);
        chk("both_done_stall", {31'd0, st}, 32'd0);
        ctrls = 3'b000;
        tick;
        chk("both_idle_req", {31'd0, bus.req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
